// File: rtl/seg_display_ctrl.sv
// Memory-mapped multiplexed common-anode 7-segment display driver.
// Bus registers DATA/CTRL/STATUS; scan FSM cycles IDLE -> DRIVE -> BLANK per digit.
module seg_display_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            addrIn,
  input  logic [7:0]            addrOut,
  input  logic [3:0]            sizeDecode,
  input  logic [31:0]           dataIn,
  output logic [31:0]           dataOut,
  output logic [7:0]            SEG,
  output logic [NUM_DIGITS-1:0] DIG
);

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [16:0]      CTRL_RST   = 17'h1_00FF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_BLANK
  } state_e;

  logic [31:0]           data_q, data_d;
  logic [16:0]           ctrl_q, ctrl_d;
  logic [31:0]           rdata_q, rdata_d;
  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] dig_q;

  logic [IDX_W-1:0]      slot_idx_c;
  logic [7:0]            slot_seg_c;
  logic [NUM_DIGITS-1:0] slot_dig_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Byte-lane merge of bus writes; CTRL keeps only its 17 implemented bits
  always_comb begin
    logic [31:0] ctrl_w;
    data_d = data_q;
    ctrl_w = {15'd0, ctrl_q};
    for (int k = 0; k < 4; k++) begin
      if (sizeDecode[k]) begin
        if (addrIn == 8'd0) data_d[8*k +: 8] = dataIn[8*k +: 8];
        if (addrIn == 8'd1) ctrl_w[8*k +: 8] = dataIn[8*k +: 8];
      end
    end
    ctrl_d = ctrl_w[16:0];
  end

  always_comb begin
    rdata_d = 32'd0;
    case (addrOut)
      8'd0:    rdata_d = data_q;
      8'd1:    rdata_d = {15'd0, ctrl_q};
      8'd2:    rdata_d = {28'd0, state_q == S_BLANK, idx_q};
      default: rdata_d = 32'd0;
    endcase
  end

  // Pattern for the slot about to start; latched only on DRIVE entry
  always_comb begin
    slot_idx_c = '0;
    if (state_q != S_IDLE && idx_q != LAST_IDX) slot_idx_c = idx_q + IDX_W'(1);
    slot_seg_c = ~{ctrl_q[{2'b01, slot_idx_c}], hex7(data_q[{slot_idx_c, 2'b00} +: 4])};
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      slot_dig_c[i] = ~(ctrl_q[i] && (slot_idx_c == IDX_W'(i)));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q  <= 32'd0;
      ctrl_q  <= CTRL_RST;
      rdata_q <= 32'd0;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
    end
  end

  // Scan FSM; global enable low forces IDLE from any state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= 8'hFF;
      dig_q   <= '1;
    end else if (!ctrl_q[16]) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= 8'hFF;
      dig_q   <= '1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_DRIVE;
          idx_q   <= slot_idx_c;
          cnt_q   <= '0;
          seg_q   <= slot_seg_c;
          dig_q   <= slot_dig_c;
        end
        S_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_q <= S_BLANK;
            cnt_q   <= '0;
            seg_q   <= 8'hFF;
            dig_q   <= '1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= S_DRIVE;
            idx_q   <= slot_idx_c;
            cnt_q   <= '0;
            seg_q   <= slot_seg_c;
            dig_q   <= slot_dig_c;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
          cnt_q   <= '0;
          seg_q   <= 8'hFF;
          dig_q   <= '1;
        end
      endcase
    end
  end

  assign dataOut = rdata_q;
  assign SEG     = seg_q;
  assign DIG     = dig_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: register table plus hand-built scan sequences.
module tb_seg_display_ctrl;

  localparam int unsigned ND = 8;
  localparam int unsigned SD = 4;
  localparam int unsigned BC = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    addrIn, addrOut;
  logic [3:0]    sizeDecode;
  logic [31:0]   dataIn;
  logic [31:0]   dataOut;
  logic [7:0]    SEG;
  logic [ND-1:0] DIG;

  int checks = 0;
  int errors = 0;

  seg_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rstn(rstn), .addrIn(addrIn), .addrOut(addrOut),
    .sizeDecode(sizeDecode), .dataIn(dataIn), .dataOut(dataOut),
    .SEG(SEG), .DIG(DIG)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  wa;
    logic [3:0]  sz;
    logic [31:0] wd;
    logic [7:0]  ra;
    logic [31:0] exp;
  } reg_vec_t;

  typedef struct {
    logic [7:0]  dig;
    logic [7:0]  seg;
    logic        chk_st;
    logic [31:0] st;
  } scan_vec_t;

  reg_vec_t  rv[11];
  scan_vec_t sv[8];
  logic [7:0] f_dig[8];
  logic [7:0] f_seg[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic [7:0] d, input logic [7:0] s);
    tick();
    check($sformatf("%s_dig", name), 32'(DIG), 32'(d));
    check($sformatf("%s_seg", name), 32'(SEG), 32'(s));
  endtask

  task automatic slot(input string name, input logic [7:0] d, input logic [7:0] s);
    for (int i = 0; i < int'(SD); i++) cyc(name, d, s);
    for (int i = 0; i < int'(BC); i++) cyc($sformatf("%s_blank", name), 8'hFF, 8'hFF);
  endtask

  task automatic set_wr(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    addrIn     = a;
    sizeDecode = s;
    dataIn     = d;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    set_wr(a, s, d);
    tick();
    sizeDecode = 4'h0;
  endtask

  // Disable then enable so the next clock starts digit 0 in DRIVE
  task automatic restart(input logic [31:0] c);
    bus_write(8'd1, 4'hF, c & 32'hFFFE_FFFF);
    bus_write(8'd1, 4'hF, c | 32'h0001_0000);
  endtask

  initial begin
    rstn = 1'b0; addrIn = 8'd0; addrOut = 8'd2; sizeDecode = 4'h0; dataIn = 32'd0;

    repeat (3) tick();
    check("rst_seg", 32'(SEG), 32'hFF);
    check("rst_dig", 32'(DIG), 32'hFF);
    check("rst_dout", dataOut, 32'd0);
    rstn = 1'b1;

    // Default scan straight out of reset: digit 0 shows '0', then blank, then digit 1
    sv[0] = '{8'hFE, 8'hC0, 1'b0, 32'd0};
    sv[1] = '{8'hFE, 8'hC0, 1'b1, 32'h0};
    sv[2] = '{8'hFE, 8'hC0, 1'b0, 32'd0};
    sv[3] = '{8'hFE, 8'hC0, 1'b0, 32'd0};
    sv[4] = '{8'hFF, 8'hFF, 1'b0, 32'd0};
    sv[5] = '{8'hFF, 8'hFF, 1'b1, 32'h8};
    sv[6] = '{8'hFD, 8'hC0, 1'b0, 32'd0};
    sv[7] = '{8'hFD, 8'hC0, 1'b1, 32'h1};
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("scan0_c%0d", i + 1), sv[i].dig, sv[i].seg);
      if (sv[i].chk_st) check($sformatf("scan0_status_c%0d", i + 1), dataOut, sv[i].st);
    end

    // Register file: write (possibly none), then read back one cycle later
    rv[0]  = '{8'd0, 4'h0, 32'h0,         8'd1, 32'h0001_00FF};
    rv[1]  = '{8'd0, 4'hF, 32'h1234_5678, 8'd0, 32'h1234_5678};
    rv[2]  = '{8'd0, 4'h2, 32'h0000_5A00, 8'd0, 32'h1234_5A78};
    rv[3]  = '{8'd0, 4'h8, 32'hAB00_0000, 8'd0, 32'hAB34_5A78};
    rv[4]  = '{8'd1, 4'hF, 32'hFFFF_FFFF, 8'd1, 32'h0001_FFFF};
    rv[5]  = '{8'd1, 4'h1, 32'h0000_0012, 8'd1, 32'h0001_FF12};
    rv[6]  = '{8'd0, 4'h0, 32'h0,         8'd5, 32'h0};
    rv[7]  = '{8'd5, 4'hF, 32'hDEAD_BEEF, 8'd0, 32'hAB34_5A78};
    rv[8]  = '{8'd0, 4'h0, 32'h0,         8'd1, 32'h0001_FF12};
    rv[9]  = '{8'd0, 4'h0, 32'hFFFF_FFFF, 8'd0, 32'hAB34_5A78};
    rv[10] = '{8'd3, 4'hF, 32'h5555_5555, 8'd3, 32'h0};
    for (int i = 0; i < 11; i++) begin
      bus_write(rv[i].wa, rv[i].sz, rv[i].wd);
      addrOut = rv[i].ra;
      tick();
      check($sformatf("reg_v%0d", i), dataOut, rv[i].exp);
    end

    // Same-cycle write and read of DATA returns the old value
    addrOut = 8'd0;
    set_wr(8'd0, 4'hF, 32'h1111_1111);
    tick();
    sizeDecode = 4'h0;
    check("rw_same_old", dataOut, 32'hAB34_5A78);
    tick();
    check("rw_same_new", dataOut, 32'h1111_1111);

    // Full frame with hex digits F..8, dp on digit 0
    bus_write(8'd0, 4'hF, 32'h89AB_CDEF);
    restart(32'h0001_01FF);
    f_dig = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    f_seg = '{8'h0E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    for (int i = 0; i < 8; i++) slot($sformatf("hex_d%0d", i), f_dig[i], f_seg[i]);

    // Only digits 0 and 2 enabled; frame length unchanged
    restart(32'h0001_0005);
    f_dig = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    f_seg[0] = 8'h8E;
    for (int i = 0; i < 8; i++) slot($sformatf("en_d%0d", i), f_dig[i], f_seg[i]);
    slot("en_wrap_d0", 8'hFE, 8'h8E);

    // Mid-slot DATA write does not tear digit 3; disable mid-slot of digit 4
    restart(32'h0001_00FF);
    slot("tear_d0", 8'hFE, 8'h8E);
    slot("tear_d1", 8'hFD, 8'h86);
    slot("tear_d2", 8'hFB, 8'hA1);
    cyc("tear_d3", 8'hF7, 8'hC6);
    cyc("tear_d3", 8'hF7, 8'hC6);
    set_wr(8'd0, 4'hF, 32'h0);
    cyc("tear_d3_wr", 8'hF7, 8'hC6);
    sizeDecode = 4'h0;
    cyc("tear_d3_after", 8'hF7, 8'hC6);
    cyc("tear_d3_blank", 8'hFF, 8'hFF);
    cyc("tear_d3_blank", 8'hFF, 8'hFF);
    cyc("tear_d4", 8'hEF, 8'hC0);
    cyc("tear_d4", 8'hEF, 8'hC0);
    addrOut = 8'd2;
    set_wr(8'd1, 4'hF, 32'h0000_00FF);
    cyc("dis_wr", 8'hEF, 8'hC0);
    sizeDecode = 4'h0;
    cyc("dis_off", 8'hFF, 8'hFF);
    check("dis_status_pre", dataOut, 32'h4);
    cyc("dis_off2", 8'hFF, 8'hFF);
    check("dis_status_idle", dataOut, 32'h0);

    // Asynchronous reset in the middle of DRIVE
    restart(32'h0001_0F0F);
    cyc("rst_mid_pre", 8'hFE, 8'h40);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_seg", 32'(SEG), 32'hFF);
    check("rst_mid_dig", 32'(DIG), 32'hFF);
    check("rst_mid_dout", dataOut, 32'd0);
    tick();
    rstn = 1'b1;
    addrOut = 8'd1;
    tick();
    check("rst_mid_ctrl", dataOut, 32'h0001_00FF);
    addrOut = 8'd0;
    tick();
    check("rst_mid_data", dataOut, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
